// File: rtl/pin_input_filter_pkg.sv
// Shared constants for the pad input filter: pin count and debounce counter width.
package pin_input_filter_pkg;

    localparam int SONATA_PIN_NUM   = 87;
    localparam int PIN_FILTER_CNT_W = 8;

    typedef logic [SONATA_PIN_NUM-1:0] sonata_pin_vec_t;

endpackage

// File: rtl/pin_input_filter_bit.sv
// One pad: 2-flop synchroniser, debounce counter, stable level, edge pulses and a sticky change flag.
module pin_filter_bit
    import pin_input_filter_pkg::*;
#(
    parameter int   FilterW    = PIN_FILTER_CNT_W,
    parameter logic ResetValue = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               pin_i,
    input  logic               filter_en_i,
    input  logic [FilterW-1:0] filter_cycles_i,
    input  logic               evt_clr_i,
    output logic               pin_o,
    output logic               rise_o,
    output logic               fall_o,
    output logic               evt_o
);

    logic               sync1_r;
    logic               sync2_r;
    logic               q_r;
    logic [FilterW-1:0] cnt_r;
    logic               rise_r;
    logic               fall_r;
    logic               evt_r;

    logic [FilterW-1:0] thresh_m1_s;
    logic               q_next_s;
    logic [FilterW-1:0] cnt_next_s;
    logic               rise_next_s;
    logic               fall_next_s;
    logic               evt_next_s;

    // Next-state for the debounce counter, stable level, pulses and sticky event.
    always_comb begin
        thresh_m1_s = {FilterW{1'b0}};
        q_next_s    = q_r;
        cnt_next_s  = {FilterW{1'b0}};
        rise_next_s = 1'b0;
        fall_next_s = 1'b0;
        evt_next_s  = evt_r;

        // A zero cycle count behaves like an unfiltered pin (one sample accepts).
        if (filter_en_i && (filter_cycles_i != {FilterW{1'b0}})) begin
            thresh_m1_s = filter_cycles_i - {{(FilterW-1){1'b0}}, 1'b1};
        end else begin
            thresh_m1_s = {FilterW{1'b0}};
        end

        // ">=" lets a threshold lowered mid-count accept on the very next cycle.
        if (sync2_r == q_r) begin
            cnt_next_s = {FilterW{1'b0}};
        end else if (cnt_r >= thresh_m1_s) begin
            q_next_s    = sync2_r;
            rise_next_s = sync2_r;
            fall_next_s = ~sync2_r;
        end else begin
            cnt_next_s = cnt_r + {{(FilterW-1){1'b0}}, 1'b1};
        end

        // Set beats clear so a change coinciding with a clear is never lost.
        if (rise_next_s || fall_next_s) begin
            evt_next_s = 1'b1;
        end else if (evt_clr_i) begin
            evt_next_s = 1'b0;
        end else begin
            evt_next_s = evt_r;
        end
    end

    // State registers, all returned to the reset level asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_r <= ResetValue;
            sync2_r <= ResetValue;
            q_r     <= ResetValue;
            cnt_r   <= {FilterW{1'b0}};
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
            evt_r   <= 1'b0;
        end else begin
            sync1_r <= pin_i;
            sync2_r <= sync1_r;
            q_r     <= q_next_s;
            cnt_r   <= cnt_next_s;
            rise_r  <= rise_next_s;
            fall_r  <= fall_next_s;
            evt_r   <= evt_next_s;
        end
    end

    assign pin_o  = q_r;
    assign rise_o = rise_r;
    assign fall_o = fall_r;
    assign evt_o  = evt_r;

endmodule

// File: rtl/pin_input_filter.sv
// Array of independent per-pad filters between the raw pads and the pin mux; no state lives here.
module pin_input_filter
    import pin_input_filter_pkg::*;
#(
    parameter int                  NumPins    = SONATA_PIN_NUM,
    parameter int                  FilterW    = PIN_FILTER_CNT_W,
    parameter logic [NumPins-1:0]  ResetValue = {NumPins{1'b0}}
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NumPins-1:0] pins_i,
    input  logic [NumPins-1:0] filter_en_i,
    input  logic [FilterW-1:0] filter_cycles_i,
    input  logic [NumPins-1:0] evt_clr_i,
    output logic [NumPins-1:0] pins_o,
    output logic [NumPins-1:0] rise_o,
    output logic [NumPins-1:0] fall_o,
    output logic [NumPins-1:0] evt_o
);

    for (genvar k = 0; k < NumPins; k++) begin : g_pin
        pin_filter_bit #(
            .FilterW    (FilterW),
            .ResetValue (ResetValue[k])
        ) u_pin (
            .clk_i           (clk_i),
            .rst_ni          (rst_ni),
            .pin_i           (pins_i[k]),
            .filter_en_i     (filter_en_i[k]),
            .filter_cycles_i (filter_cycles_i),
            .evt_clr_i       (evt_clr_i[k]),
            .pin_o           (pins_o[k]),
            .rise_o          (rise_o[k]),
            .fall_o          (fall_o[k]),
            .evt_o           (evt_o[k])
        );
    end

endmodule

// File: tb/tb_pin_input_filter.sv
// Self-checking bench for pin_input_filter: directed scenarios plus randomized traffic against a timestamp model.
module tb_pin_input_filter;
    import pin_input_filter_pkg::*;

    localparam int NP = SONATA_PIN_NUM;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic [NP-1:0] pins_i;
    logic [NP-1:0] filter_en_i;
    logic [7:0]    filter_cycles_i;
    logic [NP-1:0] evt_clr_i;
    logic [NP-1:0] pins_o;
    logic [NP-1:0] rise_o;
    logic [NP-1:0] fall_o;
    logic [NP-1:0] evt_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a pin accepts a new level once the synchronised input has
    // differed from the stable level for at least Neff consecutive samples.
    logic [NP-1:0] d1, d2, m_q, m_rise, m_fall, m_evt;
    int            last_eq [NP];
    int            cyc = 0;

    pin_input_filter dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .pins_i          (pins_i),
        .filter_en_i     (filter_en_i),
        .filter_cycles_i (filter_cycles_i),
        .evt_clr_i       (evt_clr_i),
        .pins_o          (pins_o),
        .rise_o          (rise_o),
        .fall_o          (fall_o),
        .evt_o           (evt_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        d1 = '0; d2 = '0; m_q = '0; m_rise = '0; m_fall = '0; m_evt = '0;
        for (int k = 0; k < NP; k++) last_eq[k] = cyc;
    endtask

    task automatic model_step();
        logic [NP-1:0] s;
        int            neff;
        logic          chg;
        s  = d2;
        d2 = d1;
        d1 = pins_i;
        for (int k = 0; k < NP; k++) begin
            neff      = (filter_en_i[k] && filter_cycles_i != 8'd0) ? int'(filter_cycles_i) : 1;
            m_rise[k] = 1'b0;
            m_fall[k] = 1'b0;
            chg       = 1'b0;
            if (s[k] == m_q[k]) begin
                last_eq[k] = cyc;
            end else if (cyc - last_eq[k] >= neff) begin
                m_q[k]     = s[k];
                m_rise[k]  = s[k];
                m_fall[k]  = ~s[k];
                last_eq[k] = cyc;
                chg        = 1'b1;
            end
            if (chg) m_evt[k] = 1'b1;
            else if (evt_clr_i[k]) m_evt[k] = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_ni) model_step();
        else model_reset();
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < NP; k++) pins_i[k] = 1'($urandom_range(1, 0));
            tick();
            n_checks++;
            if ({pins_o, rise_o, fall_o, evt_o} !== {(4*NP){1'b0}})
                $display("FAIL reset_hold: pins_o=%h rise=%h fall=%h evt=%h, all required 0", pins_o, rise_o, fall_o, evt_o);
            else n_pass++;
        end
        pins_i = '0;
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({pins_o, rise_o, fall_o, evt_o} !== {m_q, m_rise, m_fall, m_evt} || (rise_o | fall_o | evt_o) !== '0)
                $display("FAIL reset_release: pins_o=%h rise=%h fall=%h evt=%h, required quiet", pins_o, rise_o, fall_o, evt_o);
            else n_pass++;
        end
    endtask

    task automatic test_bypass();
        filter_en_i = '0;
        pins_i[5]   = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_checks++;
            if ({pins_o[5], rise_o[5], evt_o[5]} !== {1'(i >= 3), 1'(i == 3), 1'(i >= 3)} ||
                {pins_o, rise_o, fall_o, evt_o} !== {m_q, m_rise, m_fall, m_evt})
                $display("FAIL bypass edge %0d: q/rise/evt=%b%b%b, required %b%b%b", i,
                         pins_o[5], rise_o[5], evt_o[5], 1'(i >= 3), 1'(i == 3), 1'(i >= 3));
            else n_pass++;
        end
    endtask

    task automatic test_debounce();
        filter_en_i[7]  = 1'b1;
        filter_cycles_i = 8'd4;
        for (int i = 1; i <= 9; i++) begin
            pins_i[7] = (i <= 3) ? 1'b1 : 1'b0;
            tick();
            n_checks++;
            if ({pins_o[7], rise_o[7], fall_o[7]} !== 3'b000 || {pins_o, rise_o, fall_o, evt_o} !== {m_q, m_rise, m_fall, m_evt})
                $display("FAIL debounce_glitch edge %0d: q/rise/fall=%b%b%b, required 000", i, pins_o[7], rise_o[7], fall_o[7]);
            else n_pass++;
        end
        pins_i[7] = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            n_checks++;
            if ({pins_o[7], rise_o[7]} !== {1'(i >= 6), 1'(i == 6)} || {pins_o, rise_o, fall_o, evt_o} !== {m_q, m_rise, m_fall, m_evt})
                $display("FAIL debounce_accept edge %0d: q/rise=%b%b, required %b%b", i, pins_o[7], rise_o[7], 1'(i >= 6), 1'(i == 6));
            else n_pass++;
        end
    endtask

    task automatic test_zero_threshold();
        filter_en_i[6]  = 1'b1;
        filter_cycles_i = 8'd0;
        pins_i[6]       = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_checks++;
            if ({pins_o[6], rise_o[6]} !== {1'(i >= 3), 1'(i == 3)} || {pins_o, rise_o, fall_o, evt_o} !== {m_q, m_rise, m_fall, m_evt})
                $display("FAIL zero_threshold edge %0d: q/rise=%b%b, required %b%b", i, pins_o[6], rise_o[6], 1'(i >= 3), 1'(i == 3));
            else n_pass++;
        end
    endtask

    task automatic test_long_threshold();
        filter_en_i[9]  = 1'b1;
        filter_cycles_i = 8'd255;
        for (int i = 1; i <= 260; i++) begin
            pins_i[9] = (i <= 254) ? 1'b1 : 1'b0;
            tick();
            n_checks++;
            if (pins_o[9] !== 1'b0 || {pins_o, rise_o, fall_o, evt_o} !== {m_q, m_rise, m_fall, m_evt})
                $display("FAIL long_reject edge %0d: pins_o[9]=%b, required 0", i, pins_o[9]);
            else n_pass++;
        end
        for (int i = 1; i <= 258; i++) begin
            pins_i[9] = (i <= 255) ? 1'b1 : 1'b0;
            tick();
            n_checks++;
            if ({pins_o[9], rise_o[9]} !== {1'(i >= 257), 1'(i == 257)} || {pins_o, rise_o, fall_o, evt_o} !== {m_q, m_rise, m_fall, m_evt})
                $display("FAIL long_accept edge %0d: q/rise=%b%b, required %b%b", i, pins_o[9], rise_o[9], 1'(i >= 257), 1'(i == 257));
            else n_pass++;
        end
        filter_en_i[9] = 1'b0;
    endtask

    task automatic test_threshold_change();
        filter_en_i[11] = 1'b1;
        filter_cycles_i = 8'd10;
        pins_i[11]      = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            if (i == 9) filter_cycles_i = 8'd3;
            tick();
            n_checks++;
            if ({pins_o[11], rise_o[11]} !== {1'(i == 9), 1'(i == 9)} || {pins_o, rise_o, fall_o, evt_o} !== {m_q, m_rise, m_fall, m_evt})
                $display("FAIL threshold_change edge %0d: q/rise=%b%b, required %b%b", i, pins_o[11], rise_o[11], 1'(i == 9), 1'(i == 9));
            else n_pass++;
        end
    endtask

    task automatic test_evt_collision();
        filter_en_i[0] = 1'b0;
        pins_i[0]      = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            evt_clr_i[0] = (i == 3 || i == 4) ? 1'b1 : 1'b0;
            tick();
            n_checks++;
            if ({pins_o[0], evt_o[0]} !== {1'(i >= 3), 1'(i == 3)} || {pins_o, rise_o, fall_o, evt_o} !== {m_q, m_rise, m_fall, m_evt})
                $display("FAIL evt_collision edge %0d: q/evt=%b%b, required %b%b", i, pins_o[0], evt_o[0], 1'(i >= 3), 1'(i == 3));
            else n_pass++;
        end
        evt_clr_i = '0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 700; i++) begin
            if (i % 50 == 0) begin
                for (int k = 0; k < NP; k++) filter_en_i[k] = 1'($urandom_range(1, 0));
                filter_cycles_i = 8'($urandom_range(6, 0));
            end
            for (int k = 0; k < NP; k++) begin
                if ($urandom_range(5, 0) == 0) pins_i[k] = ~pins_i[k];
                evt_clr_i[k] = ($urandom_range(9, 0) == 0);
            end
            if (i == 350) begin
                #2 rst_ni = 1'b0;
                model_reset();
            end
            if (i == 353) rst_ni = 1'b1;
            tick();
            n_checks++;
            if ({pins_o, rise_o, fall_o, evt_o} !== {m_q, m_rise, m_fall, m_evt})
                $display("FAIL random cycle %0d: pins_o=%h rise=%h fall=%h evt=%h, required %h %h %h %h", i,
                         pins_o, rise_o, fall_o, evt_o, m_q, m_rise, m_fall, m_evt);
            else n_pass++;
        end
    endtask

    initial begin
        rst_ni          = 1'b0;
        pins_i          = '0;
        filter_en_i     = '0;
        filter_cycles_i = 8'd0;
        evt_clr_i       = '0;
        #2;
        test_reset();
        test_bypass();
        test_debounce();
        test_zero_threshold();
        test_long_threshold();
        test_threshold_change();
        test_evt_collision();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
